instr_loader: RTL and testbench

- Front-end stage that sits directly upstream of the bit-serial CPU core.
- Assembles one 16-bit instruction from four button-strobed 4-bit nibbles on the input switches.
- Drives the core's opcode, instr[11:0], inst_done and btn_edge inputs.
- Owns input synchronisation, button debouncing and rising-edge detection, so the core only ever sees clean single-cycle pulses.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/btn_debounce.sv | 90 +++++++++
 rtl/instr_loader.sv | 95 +++++++++
 tb/tb_instr_loader.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared widths and capture-phase encoding for the CPU front end.
package cpu_pkg;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned INSTR_W  = 12;
  localparam int unsigned NIB_W    = 4;

  // Capture phase; the encoding doubles as the index of the next nibble.
  typedef enum logic [1:0] {
    P_OP  = 2'd0,
    P_HI  = 2'd1,
    P_MID = 2'd2,
    P_LO  = 2'd3
  } phase_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop sync, counter debounce, rising-edge pulse.
// With INSTR_LOADER_LONGPRESS_ABORT_EN defined, a saturating hold counter
// also emits a single long_press pulse once a hold reaches LONG_CYCLES.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES  = 16,
  parameter int unsigned LONG_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic rise,
  output logic long_press
);

  localparam int unsigned DEB_W = $clog2(DEB_CYCLES);

  if (DEB_CYCLES < 2) begin : g_bad_deb_cycles
    $error("btn_debounce: DEB_CYCLES must be >= 2");
  end
  if (LONG_CYCLES < 2) begin : g_bad_long_cycles
    $error("btn_debounce: LONG_CYCLES must be >= 2");
  end

  logic             sync_q1;
  logic             sync_q2;
  logic [DEB_W-1:0] deb_cnt;
  logic             level_q;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Level follows the synced input only after DEB_CYCLES consecutive disagreements.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level   <= 1'b0;
      deb_cnt <= '0;
    end else if (sync_q2 == level) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
      level   <= sync_q2;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  // Registered single-cycle pulse on each debounced rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      rise    <= 1'b0;
    end else begin
      level_q <= level;
      rise    <= level & ~level_q;
    end
  end

`ifdef INSTR_LOADER_LONGPRESS_ABORT_EN
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

  logic [HOLD_W-1:0] hold_cnt;

  // Saturating hold counter; saturation makes the pulse fire once per hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt   <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= level && (hold_cnt == HOLD_W'(LONG_CYCLES - 1));
      if (!level) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_W'(LONG_CYCLES)) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: rtl/instr_loader.sv
// Assembles a 16-bit instruction from four button-strobed switch nibbles and
// presents it to the bit-serial core with a one-cycle inst_done pulse.
// Optional long-press abort: define INSTR_LOADER_LONGPRESS_ABORT_EN.
module instr_loader
  import cpu_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 16,
  parameter int unsigned LONG_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NIB_W-1:0]    nib_in,
  input  logic                btn_raw,
  output logic [OPCODE_W-1:0] opcode,
  output logic [INSTR_W-1:0]  instr,
  output logic                inst_done,
  output logic                btn_edge,
  output logic [1:0]          nib_idx
);

  logic [NIB_W-1:0] nib_q1;
  logic [NIB_W-1:0] nib_q2;
  logic             btn_level;
  logic             long_press;
  logic             abort;
  phase_t           phase;
  // Holds opcode, high and mid nibbles; the low nibble goes straight to instr.
  logic [11:0]      shadow;

  btn_debounce #(
    .DEB_CYCLES  (DEB_CYCLES),
    .LONG_CYCLES (LONG_CYCLES)
  ) u_btn (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .level      (btn_level),
    .rise       (btn_edge),
    .long_press (long_press)
  );

  // An abort only counts while the button is still held.
  assign abort   = long_press & btn_level;
  assign nib_idx = phase;

  // Two-flop synchroniser for the switch nibble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nib_q1 <= '0;
      nib_q2 <= '0;
    end else begin
      nib_q1 <= nib_in;
      nib_q2 <= nib_q1;
    end
  end

  // Capture FSM: one nibble per button edge, commit on the fourth.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase     <= P_OP;
      shadow    <= '0;
      opcode    <= '0;
      instr     <= '0;
      inst_done <= 1'b0;
    end else begin
      inst_done <= 1'b0;
      if (abort) begin
        phase  <= P_OP;
        shadow <= '0;
      end else if (btn_edge) begin
        case (phase)
          P_OP: begin
            shadow[11:8] <= nib_q2;
            phase        <= P_HI;
          end
          P_HI: begin
            shadow[7:4] <= nib_q2;
            phase       <= P_MID;
          end
          P_MID: begin
            shadow[3:0] <= nib_q2;
            phase       <= P_LO;
          end
          P_LO: begin
            opcode    <= shadow[11:8];
            instr     <= {shadow[7:0], nib_q2};
            inst_done <= 1'b1;
            phase     <= P_OP;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader (DEB_CYCLES=16, LONG_CYCLES=64).
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  nib_in;
  logic        btn_raw;
  logic [3:0]  opcode;
  logic [11:0] instr;
  logic        inst_done;
  logic        btn_edge;
  logic [1:0]  nib_idx;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int DEB = 16;

  instr_loader #(
    .DEB_CYCLES  (16),
    .LONG_CYCLES (64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .nib_in    (nib_in),
    .btn_raw   (btn_raw),
    .opcode    (opcode),
    .instr     (instr),
    .inst_done (inst_done),
    .btn_edge  (btn_edge),
    .nib_idx   (nib_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Hold the button for 'hold' cycles then release for 25; report edge latency and pulse counts.
  task automatic press(input logic [3:0] nib, input int hold,
                       output int lat, output int n_edge, output int n_done);
    lat = -1; n_edge = 0; n_done = 0;
    nib_in  = nib;
    btn_raw = 1'b1;
    for (int i = 1; i <= hold + 25; i++) begin
      if (i == hold + 1) btn_raw = 1'b0;
      tick();
      if (btn_edge === 1'b1) begin
        n_edge++;
        if (lat < 0) lat = i;
      end
      if (inst_done === 1'b1) n_done++;
    end
  endtask

  // Ordinary 20-cycle press; checks latency and single edge, returns inst_done count.
  task automatic key(input string tag, input logic [3:0] nib, output int n_done);
    int lat, n_edge;
    press(nib, 20, lat, n_edge, n_done);
    check({tag, "_latency"}, lat, DEB + 3);
    check({tag, "_edges"}, n_edge, 1);
  endtask

  initial begin
    int d, dsum, lat, n_edge;
    rst_n = 1'b0; btn_raw = 1'b0; nib_in = 4'h0;

    // Reset
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_opcode", opcode, 0);
    check("rst_instr", instr, 0);
    check("rst_inst_done", inst_done, 0);
    check("rst_btn_edge", btn_edge, 0);
    check("rst_nib_idx", nib_idx, 0);

    // Clean load 0x9A53
    key("load0", 4'h9, d); check("load0_done", d, 0); check("load0_idx", nib_idx, 1);
    check("load0_opcode_held", opcode, 0);
    key("load1", 4'hA, d); check("load1_done", d, 0); check("load1_idx", nib_idx, 2);
    key("load2", 4'h5, d); check("load2_done", d, 0); check("load2_idx", nib_idx, 3);
    key("load3", 4'h3, d); check("load3_done", d, 1); check("load3_idx", nib_idx, 0);
    check("load_opcode", opcode, 4'h9);
    check("load_instr", instr, 12'hA53);
    check("load_done_low", inst_done, 0);

    // Hold stability while keying 0x1234
    dsum = 0;
    key("hold0", 4'h1, d); dsum += d;
    key("hold1", 4'h2, d); dsum += d;
    key("hold2", 4'h3, d); dsum += d;
    check("hold_no_done", dsum, 0);
    check("hold_opcode", opcode, 4'h9);
    check("hold_instr", instr, 12'hA53);
    key("hold3", 4'h4, d);
    check("hold3_done", d, 1);
    check("hold_new_opcode", opcode, 4'h1);
    check("hold_new_instr", instr, 12'h234);

    // Bounce rejection: 3-cycle pulses for 40 cycles, then quiet
    n_edge = 0;
    nib_in = 4'hE;
    for (int i = 0; i < 40; i++) begin
      btn_raw = ((i / 3) % 2) == 0;
      tick();
      if (btn_edge === 1'b1) n_edge++;
    end
    btn_raw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (btn_edge === 1'b1) n_edge++;
    end
    check("bounce_edges", n_edge, 0);
    check("bounce_idx", nib_idx, 0);
    key("bounce_clean", 4'h7, d);
    check("bounce_clean_idx", nib_idx, 1);

    // Reset mid-load after two nibbles
    key("mid1", 4'h8, d);
    check("mid_idx_before", nib_idx, 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_rst_idx", nib_idx, 0);
    check("mid_rst_opcode", opcode, 0);
    check("mid_rst_instr", instr, 0);
    dsum = 0;
    key("relo0", 4'hF, d); dsum += d;
    key("relo1", 4'h0, d); dsum += d;
    key("relo2", 4'h0, d); dsum += d;
    key("relo3", 4'h1, d); dsum += d;
    check("relo_done", dsum, 1);
    check("relo_opcode", opcode, 4'hF);
    check("relo_instr", instr, 12'h001);

`ifdef INSTR_LOADER_LONGPRESS_ABORT_EN
    // Long press aborts a partial load without committing
    key("lp0", 4'h2, d);
    key("lp1", 4'h3, d);
    check("lp_idx_before", nib_idx, 2);
    press(4'h4, 100, lat, n_edge, d);
    check("lp_latency", lat, DEB + 3);
    check("lp_edges", n_edge, 1);
    check("lp_no_done", d, 0);
    check("lp_idx", nib_idx, 0);
    check("lp_opcode", opcode, 4'hF);
    check("lp_instr", instr, 12'h001);
    dsum = 0;
    key("post0", 4'hA, d); dsum += d;
    key("post1", 4'hB, d); dsum += d;
    key("post2", 4'hC, d); dsum += d;
    key("post3", 4'hD, d); dsum += d;
    check("post_done", dsum, 1);
    check("post_opcode", opcode, 4'hA);
    check("post_instr", instr, 12'hBCD);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
